uart_baud_timer: RTL and testbench

UART_BAUD_TIMER -- requirements
Module: uart_baud_timer

---
 rtl/uart_baud_timer.sv | 131 +++++++++++++
 tb/tb_uart_baud_timer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_timer.sv
// Bit-period timer for a UART: counts divisor clocks per bit and emits one tick per
// bit boundary (TX) or per mid-bit sample point (RX, first period halved).
module uart_baud_timer #(
    parameter int CNT_W = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] divisor,
    input  logic [IDX_W-1:0] num_bits,
    input  logic             half_first,
    output logic             bit_tick,
    output logic [IDX_W-1:0] bit_index,
    output logic             frame_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HALF = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_div, w_div_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0] r_nbits, w_nbits_nxt;
    logic [IDX_W-1:0] r_tcnt, w_tcnt_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_tick, w_tick_nxt;
    logic             r_done, w_done_nxt;
    logic             r_busy, w_busy_nxt;

    logic [CNT_W-1:0] w_div_eff;
    logic [CNT_W-1:0] w_half_eff;
    logic [CNT_W-1:0] w_period;
    logic [IDX_W-1:0] w_last;
    logic             w_period_end;

    // Zero divisor / frame length behave as 1 so the frame always terminates.
    assign w_div_eff    = (r_div == '0) ? CNT_W'(1) : r_div;
    assign w_half_eff   = ((w_div_eff >> 1) == '0) ? CNT_W'(1) : (w_div_eff >> 1);
    assign w_period     = (r_state == S_HALF) ? w_half_eff : w_div_eff;
    assign w_period_end = (r_cnt == w_period - CNT_W'(1));
    assign w_last       = (r_nbits == '0) ? '0 : r_nbits - IDX_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_nbits_nxt = r_nbits;
        w_tcnt_nxt  = r_tcnt;
        w_idx_nxt   = r_idx;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_div_nxt   = divisor;
                    w_nbits_nxt = num_bits;
                    w_cnt_nxt   = '0;
                    w_tcnt_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = half_first ? S_HALF : S_RUN;
                end
            end
            S_HALF, S_RUN: begin
                // Abort outranks a tick falling on the same edge.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_tcnt_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                end else if (w_period_end) begin
                    w_cnt_nxt  = '0;
                    w_tick_nxt = 1'b1;
                    w_idx_nxt  = r_tcnt;
                    if (r_tcnt == w_last) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_tcnt_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tcnt_nxt  = r_tcnt + IDX_W'(1);
                        w_state_nxt = S_RUN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_nbits <= '0;
            r_tcnt  <= '0;
            r_idx   <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
            r_nbits <= w_nbits_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_idx   <= w_idx_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign bit_tick   = r_tick;
    assign bit_index  = r_idx;
    assign frame_done = r_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_baud_timer.sv
// Bench for uart_baud_timer: a tick-schedule model (tick k at accept+first+k*D)
// checked every cycle, plus literal tick-time expectations per scenario.
module tb_uart_baud_timer;

    localparam int CNT_W = 16;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             reset, start, abort, half_first;
    logic [CNT_W-1:0] divisor;
    logic [IDX_W-1:0] num_bits;
    logic             bit_tick, frame_done, busy;
    logic [IDX_W-1:0] bit_index;

    uart_baud_timer #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .divisor    (divisor),
        .num_bits   (num_bits),
        .half_first (half_first),
        .bit_tick   (bit_tick),
        .bit_index  (bit_index),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // model state
    bit             m_busy = 1'b0;
    int             m_e, m_d, m_n, m_first;
    logic           exp_tick = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
    logic [IDX_W-1:0] exp_idx = '0;

    int ticks_q[$];
    int idx_q[$];
    int done_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Model: each edge, decide outputs from the frame's tick schedule.
    initial begin
        int t, k, d, n;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            exp_tick = 1'b0;
            exp_done = 1'b0;
            if (reset) begin
                m_busy = 1'b0; exp_busy = 1'b0; exp_idx = '0;
            end else if (m_busy) begin
                if (abort) begin
                    m_busy = 1'b0; exp_busy = 1'b0;
                end else begin
                    t = cyc - m_e;
                    if (t >= m_first && ((t - m_first) % m_d) == 0) begin
                        k = (t - m_first) / m_d;
                        exp_tick = 1'b1;
                        exp_idx  = IDX_W'(k);
                        if (k == m_n - 1) begin
                            exp_done = 1'b1; m_busy = 1'b0; exp_busy = 1'b0;
                        end
                    end
                end
            end else if (start && !abort) begin
                d = (divisor == '0) ? 1 : int'(divisor);
                n = (num_bits == '0) ? 1 : int'(num_bits);
                m_d = d;
                m_n = n;
                m_first = half_first ? (((d / 2) == 0) ? 1 : d / 2) : d;
                m_e = cyc;
                m_busy = 1'b1; exp_busy = 1'b1; exp_idx = '0;
            end
        end
    end

    // Compare process: outputs sampled mid-cycle against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("bit_tick",   32'(bit_tick),   32'(exp_tick));
                chk("frame_done", 32'(frame_done), 32'(exp_done));
                chk("busy",       32'(busy),       32'(exp_busy));
                chk("bit_index",  32'(bit_index),  32'(exp_idx));
                if (bit_tick === 1'b1) begin
                    ticks_q.push_back(cyc);
                    idx_q.push_back(int'(bit_index));
                end
                if (frame_done === 1'b1) done_q.push_back(cyc);
            end
        end
    end

    task automatic clear_q();
        ticks_q.delete(); idx_q.delete(); done_q.delete();
    endtask

    task automatic start_frame(input int d, input int n, input bit h, output int e);
        divisor    = CNT_W'(d);
        num_bits   = IDX_W'(n);
        half_first = h;
        start      = 1'b1;
        e          = cyc + 1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        chk("idle within bound", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int e, e2;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        divisor = '0; num_bits = '0; half_first = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset busy",  32'(busy),       32'd0);
        chk("reset tick",  32'(bit_tick),   32'd0);
        chk("reset done",  32'(frame_done), 32'd0);
        chk("reset index", 32'(bit_index),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        // D=4 N=3 TX; start held across the final-tick edge must be ignored
        clear_q();
        start_frame(4, 3, 1'b0, e);
        repeat (11) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(10);
        chk("t1 ticks", 32'(ticks_q.size()), 32'd3);
        chk("t1 tick0", 32'(ticks_q[0]), 32'(e + 4));
        chk("t1 tick1", 32'(ticks_q[1]), 32'(e + 8));
        chk("t1 tick2", 32'(ticks_q[2]), 32'(e + 12));
        chk("t1 idx2",  32'(idx_q[2]),   32'd2);
        chk("t1 done",  32'(done_q[0]),  32'(e + 12));
        chk("t1 ndone", 32'(done_q.size()), 32'd1);

        // D=8 N=2 RX: half period first
        clear_q();
        start_frame(8, 2, 1'b1, e);
        wait_idle(20);
        chk("t2 tick0", 32'(ticks_q[0]), 32'(e + 4));
        chk("t2 tick1", 32'(ticks_q[1]), 32'(e + 12));
        chk("t2 done",  32'(done_q[0]),  32'(e + 12));

        // zero divisor and zero length
        clear_q();
        start_frame(0, 0, 1'b0, e);
        wait_idle(5);
        chk("t3 ticks", 32'(ticks_q.size()), 32'd1);
        chk("t3 tick0", 32'(ticks_q[0]), 32'(e + 1));
        chk("t3 done",  32'(done_q[0]),  32'(e + 1));

        // D=1 half: half period clamps to 1
        clear_q();
        start_frame(1, 2, 1'b1, e);
        wait_idle(5);
        chk("t3b tick0", 32'(ticks_q[0]), 32'(e + 1));
        chk("t3b tick1", 32'(ticks_q[1]), 32'(e + 2));

        // settings changed and start pulsed mid-frame
        clear_q();
        start_frame(10, 4, 1'b0, e);
        repeat (2) @(negedge clk);
        divisor = 16'd3; num_bits = 4'd1; half_first = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(60);
        chk("t4 ticks", 32'(ticks_q.size()), 32'd4);
        chk("t4 tick0", 32'(ticks_q[0]), 32'(e + 10));
        chk("t4 tick3", 32'(ticks_q[3]), 32'(e + 40));
        chk("t4 idx3",  32'(idx_q[3]),   32'd3);
        chk("t4 done",  32'(done_q[0]),  32'(e + 40));

        // abort on the second-tick edge, restart right after
        clear_q();
        start_frame(6, 5, 1'b0, e);
        repeat (11) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5 busy after abort", 32'(busy),     32'd0);
        chk("t5 no tick",          32'(bit_tick), 32'd0);
        start_frame(2, 1, 1'b0, e2);
        wait_idle(10);
        chk("t5 ticks", 32'(ticks_q.size()), 32'd2);
        chk("t5 tick0", 32'(ticks_q[0]), 32'(e + 6));
        chk("t5 tick1", 32'(ticks_q[1]), 32'(e + 15));
        chk("t5 ndone", 32'(done_q.size()), 32'd1);
        chk("t5 done",  32'(done_q[0]),  32'(e + 15));

        // reset mid-frame (with start asserted), then start+abort in idle
        clear_q();
        start_frame(5, 3, 1'b0, e);
        repeat (6) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("t6 busy",  32'(busy),       32'd0);
        chk("t6 tick",  32'(bit_tick),   32'd0);
        chk("t6 done",  32'(frame_done), 32'd0);
        chk("t6 index", 32'(bit_index),  32'd0);
        divisor = 16'd2; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("t6 abort wins", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("t6 ticks", 32'(ticks_q.size()), 32'd1);
        chk("t6 tick0", 32'(ticks_q[0]), 32'(e + 5));

        // assorted frames, checked by the model
        begin
            int tab_d[4] = '{3, 7, 2, 5};
            int tab_n[4] = '{4, 2, 15, 1};
            bit tab_h[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 4; i++) begin
                clear_q();
                start_frame(tab_d[i], tab_n[i], tab_h[i], e);
                wait_idle(tab_d[i] * tab_n[i] + 10);
                chk("table ticks", 32'(ticks_q.size()), 32'(tab_n[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
